cache_nway: RTL and testbench

- Parameterised N-way set-associative, write-back, write-allocate cache between the pipeline's CPU memory port and the 256-bit physical-memory port.
- Next generation of the two-level cache: set count and associativity are generic.
- Adds tree pseudo-LRU replacement, invalid-way-first allocation, and hit/miss performance counters.
- Used as both I-cache and D-cache; the CPU and pmem handshakes are unchanged from the current cache.

---
 rtl/cache_nway_pkg.sv | 23 ++
 rtl/cache_plru.sv | 50 +++++
 rtl/cache_nway.sv | 187 ++++++++++++++++++
 tb/tb_cache_nway.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_nway_pkg.sv
// Shared constants, FSM state type and address-geometry helpers for cache_nway.
package cache_nway_pkg;

    localparam int OFFSET_W = 5;
    localparam int LINE_W   = 256;
    localparam int WSEL_W   = 3;
    localparam int WORDS    = 8;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_e;

    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int num_sets);
        return 32 - OFFSET_W - idx_w(num_sets);
    endfunction

endpackage

// File: rtl/cache_plru.sv
// Tree pseudo-LRU: heap-ordered node bits (node n has children 2n+1 / 2n+2),
// bit = 0 sends the victim search left. Pure combinational.
module cache_plru
    import cache_nway_pkg::*;
#(
    parameter  int NUM_WAYS = 2,
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int PB       = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
    input  logic [PB-1:0]    bits_i,
    input  logic [WAY_W-1:0] access_way_i,
    output logic [WAY_W-1:0] victim_o,
    output logic [PB-1:0]    bits_o
);

    generate
        if (NUM_WAYS == 1) begin : g_direct
            assign victim_o = '0;
            assign bits_o   = bits_i;
        end else begin : g_tree
            localparam int LEVELS = $clog2(NUM_WAYS);
            logic [PB-1:0] tree;
            int node;
            int vic;
            int dir;

            always_comb begin
                tree = bits_i;
                node = 0;
                vic  = 0;
                dir  = 0;
                for (int lvl = 0; lvl < LEVELS; lvl++) begin
                    dir  = int'(bits_i[WAY_W'(node)]);
                    vic  = 2 * vic + dir;
                    node = 2 * node + 1 + dir;
                end
                victim_o = WAY_W'(vic);
                // Walk the accessed way's path and point each node away from it.
                node = 0;
                for (int lvl = 0; lvl < LEVELS; lvl++) begin
                    dir = (int'(access_way_i) >> (LEVELS - 1 - lvl)) & 1;
                    tree[WAY_W'(node)] = (dir == 0);
                    node = 2 * node + 1 + dir;
                end
                bits_o = tree;
            end
        end
    endgenerate

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back / write-allocate cache with tree PLRU,
// invalid-way-first allocation and hit/miss counters.
module cache_nway
    import cache_nway_pkg::*;
#(
    parameter int NUM_SETS  = 8,
    parameter int NUM_WAYS  = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [3:0]           mem_byte_enable,
    input  logic [31:0]          mem_address,
    input  logic [31:0]          mem_wdata,
    output logic                 mem_resp,
    output logic [31:0]          mem_rdata,
    input  logic                 pmem_resp,
    input  logic [255:0]         pmem_rdata,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_address,
    output logic [255:0]         pmem_wdata,
    output logic                 if_miss,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int IDX_W = idx_w(NUM_SETS);
    localparam int TAG_W = tag_w(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int PB    = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    logic [LINE_W-1:0]   data_q  [NUM_WAYS][NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [PB-1:0]       plru_q  [NUM_SETS];

    state_e               state_q, state_d;
    logic [WAY_W-1:0]     victim_q, victim_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

    logic                req;
    logic                hit;
    logic                has_inv;
    logic                unused_addr_bits;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    req_tag;
    logic [WSEL_W-1:0]   wsel;
    logic [NUM_WAYS-1:0] way_hit;
    logic [WAY_W-1:0]    hit_way, inv_way, plru_victim, miss_way;
    logic [PB-1:0]       plru_next;
    logic [LINE_W-1:0]   hit_line, merged_line;
    logic [31:0]         line_words [WORDS];

    assign req              = mem_read | mem_write;
    assign idx              = mem_address[OFFSET_W +: IDX_W];
    assign req_tag          = mem_address[31 -: TAG_W];
    assign wsel             = mem_address[OFFSET_W-1 -: WSEL_W];
    assign unused_addr_bits = ^mem_address[1:0];

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign way_hit[gi] = valid_q[idx][gi] && (tag_q[gi][idx] == req_tag);
        end
    endgenerate

    assign hit = |way_hit;

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        has_inv = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) hit_way = WAY_W'(w);
            if (!valid_q[idx][w]) begin
                inv_way = WAY_W'(w);
                has_inv = 1'b1;
            end
        end
    end

    cache_plru #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .bits_i       (plru_q[idx]),
        .access_way_i (hit_way),
        .victim_o     (plru_victim),
        .bits_o       (plru_next)
    );

    assign miss_way = has_inv ? inv_way : plru_victim;
    assign hit_line = data_q[hit_way][idx];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign line_words[gi] = hit_line[gi*32 +: 32];
        end
        for (genvar gi = 0; gi < LINE_W / 8; gi++) begin : g_byte
            assign merged_line[gi*8 +: 8] =
                (wsel == WSEL_W'(gi / 4) && mem_byte_enable[gi % 4])
                    ? mem_wdata[(gi % 4)*8 +: 8] : hit_line[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if_miss      = 1'b0;
        case (state_q)
            CHECK: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        if (!mem_write) mem_rdata = line_words[wsel];
                    end else begin
                        if_miss  = 1'b1;
                        victim_d = miss_way;
                        state_d  = (valid_q[idx][miss_way] && dirty_q[idx][miss_way])
                                   ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[victim_q][idx], idx, {OFFSET_W{1'b0}}};
                pmem_wdata   = data_q[victim_q][idx];
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, idx, {OFFSET_W{1'b0}}};
                if (pmem_resp) state_d = CHECK;
            end
            default: state_d = CHECK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CHECK;
            victim_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (mem_resp) begin
                hit_cnt_q   <= hit_cnt_q + CNT_WIDTH'(1);
                plru_q[idx] <= plru_next;
                if (mem_write) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (if_miss) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
            if (state_q == FILL && pmem_resp) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

    // Line and tag storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (mem_resp && mem_write) data_q[hit_way][idx] <= merged_line;
            if (state_q == FILL && pmem_resp) begin
                data_q[victim_q][idx] <= pmem_rdata;
                tag_q[victim_q][idx]  <= req_tag;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_nway.sv
// Randomised bench for cache_nway (8 sets, 4 ways) against a behavioural cache model.
module tb_cache_nway;

    localparam int NSETS = 8;
    localparam int NWAYS = 4;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write;
    logic [3:0]    mem_byte_enable;
    logic [31:0]   mem_address, mem_wdata;
    logic          mem_resp;
    logic [31:0]   mem_rdata;
    logic          pmem_resp;
    logic [255:0]  pmem_rdata;
    logic          pmem_read, pmem_write;
    logic [31:0]   pmem_address;
    logic [255:0]  pmem_wdata;
    logic          if_miss;
    logic [CW-1:0] hit_count, miss_count;

    always #5 clk = ~clk;

    cache_nway #(.NUM_SETS(NSETS), .NUM_WAYS(NWAYS), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_resp       (pmem_resp),
        .pmem_rdata      (pmem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .if_miss         (if_miss),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] line_init(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = (la + 32'(k * 4)) ^ 32'hA5A5_0000;
        return l;
    endfunction

    // ---------------- physical memory responder ----------------
    logic [255:0] pmem_store [int unsigned];
    bit           hold = 1'b0;
    int           stray_req = 0;
    int           stray_done = 0;
    bit           busy = 1'b0;
    bit           cur_is_write;
    int           lat;
    int           wb_cnt = 0, fill_cnt = 0, both_hi = 0;
    logic [31:0]  wb_addr_seen, fill_addr_seen;
    logic [255:0] wb_data_seen;

    initial begin : responder
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) both_hi++;
            if (rst) begin
                busy = 1'b0;
            end else if (stray_req != stray_done) begin
                pmem_resp = 1'b1;
                stray_done++;
            end else if (busy) begin
                if (!hold) begin
                    if (lat == 0) begin
                        if (cur_is_write) pmem_store[wb_addr_seen] = wb_data_seen;
                        else pmem_rdata = pmem_store.exists(fill_addr_seen)
                                          ? pmem_store[fill_addr_seen] : line_init(fill_addr_seen);
                        pmem_resp = 1'b1;
                        busy = 1'b0;
                    end else begin
                        lat--;
                    end
                end
            end else if (pmem_read || pmem_write) begin
                busy = 1'b1;
                lat = $urandom_range(0, 3);
                cur_is_write = pmem_write;
                if (pmem_write) begin
                    wb_cnt++;
                    wb_addr_seen = pmem_address;
                    wb_data_seen = pmem_wdata;
                end else begin
                    fill_cnt++;
                    fill_addr_seen = pmem_address;
                end
            end
        end
    end

    // ---------------- behavioural cache model ----------------
    logic [255:0] ref_mem [int unsigned];
    bit           m_valid [NSETS][NWAYS];
    bit           m_dirty [NSETS][NWAYS];
    int unsigned  m_tag   [NSETS][NWAYS];
    logic [255:0] m_data  [NSETS][NWAYS];
    bit           m_plru  [NSETS][NWAYS];
    int           m_hits, m_misses;

    task automatic m_reset();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < NWAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_plru[s][w]  = 0;
            end
        m_hits = 0;
        m_misses = 0;
    endtask

    function automatic int m_victim(input int s);
        int node = 0;
        while (node < NWAYS - 1) node = 2 * node + 1 + int'(m_plru[s][node]);
        return node - (NWAYS - 1);
    endfunction

    // Climb from the accessed leaf; each parent points at the sibling subtree.
    task automatic m_touch(input int s, input int w);
        int leaf = w + NWAYS - 1;
        int parent;
        while (leaf > 0) begin
            parent = (leaf - 1) / 2;
            m_plru[s][parent] = (leaf == 2 * parent + 1);
            leaf = parent;
        end
    endtask

    logic [31:0] last_rdata;
    int          txn = 0;

    task automatic cpu_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wd);
        int unsigned s, t, wi;
        int hw, vw, wb0, f0, misses_seen;
        bit exp_miss, exp_wb, got;
        logic [31:0]  exp_wb_addr, exp_fill_addr, exp_rdata;
        logic [255:0] exp_wb_data, line;
        s = (addr >> 5) & 7;
        t = addr >> 8;
        wi = (addr >> 2) & 7;
        hw = -1;
        for (int w = 0; w < NWAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        exp_miss = (hw < 0);
        exp_wb = 0;
        exp_wb_addr = '0;
        exp_wb_data = '0;
        exp_fill_addr = addr & ~32'h1F;
        if (exp_miss) begin
            vw = -1;
            for (int w = NWAYS - 1; w >= 0; w--) if (!m_valid[s][w]) vw = w;
            if (vw < 0) vw = m_victim(s);
            if (m_valid[s][vw] && m_dirty[s][vw]) begin
                exp_wb = 1;
                exp_wb_addr = (m_tag[s][vw] << 8) | (s << 5);
                exp_wb_data = m_data[s][vw];
                ref_mem[exp_wb_addr] = m_data[s][vw];
            end
            m_data[s][vw] = ref_mem.exists(exp_fill_addr) ? ref_mem[exp_fill_addr]
                                                           : line_init(exp_fill_addr);
            m_valid[s][vw] = 1;
            m_dirty[s][vw] = 0;
            m_tag[s][vw] = t;
            hw = vw;
            m_misses++;
        end
        m_touch(s, hw);
        m_hits++;
        line = m_data[s][hw];
        exp_rdata = line[wi*32 +: 32];
        if (wr) begin
            for (int b = 0; b < 4; b++) if (be[b]) line[wi*32 + b*8 +: 8] = wd[b*8 +: 8];
            m_data[s][hw] = line;
            m_dirty[s][hw] = 1;
        end

        wb0 = wb_cnt;
        f0 = fill_cnt;
        misses_seen = 0;
        got = 0;
        @(posedge clk);
        #1;
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_byte_enable = be;
        mem_wdata = wd;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (if_miss) misses_seen++;
            if (mem_resp) begin
                got = 1;
                last_rdata = mem_rdata;
            end
        end
        chk("resp_seen", got, 1);
        @(posedge clk);
        #1;
        mem_read = 0;
        mem_write = 0;
        @(negedge clk);
        chk("resp_single", mem_resp, 0);
        chk("if_miss", misses_seen, exp_miss);
        chk("wb_count", wb_cnt - wb0, exp_wb);
        if (exp_wb) begin
            chk("wb_addr", wb_addr_seen, exp_wb_addr);
            chk("wb_data", wb_data_seen, exp_wb_data);
        end
        chk("fill_count", fill_cnt - f0, exp_miss);
        if (exp_miss) chk("fill_addr", fill_addr_seen, exp_fill_addr);
        if (!wr) chk("rdata", last_rdata, exp_rdata);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
        txn++;
        $display("txn %0d rd=%0b wr=%0b addr=%08h be=%h miss=%0b wb=%0b rdata=%08h hits=%0d misses=%0d",
                 txn, rd, wr, addr, be, exp_miss, exp_wb, last_rdata, hit_count, miss_count);
    endtask

    initial begin : main
        logic [255:0] l40;
        int w0, f0, wait_c;
        rst = 1'b1;
        mem_read = 0;
        mem_write = 0;
        mem_byte_enable = '0;
        mem_address = '0;
        mem_wdata = '0;
        l40 = line_init(32'h40);
        l40[31:0]  = 32'hDEADBEEF;
        l40[63:32] = 32'hAABBCCDD;
        pmem_store[32'h40] = l40;
        ref_mem[32'h40] = l40;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_addr", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_if_miss", if_miss, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);

        // First read misses and fills from 0x40.
        cpu_access(1, 0, 32'h40, 4'h0, 32'h0);
        chk("t1_rdata", last_rdata, 32'hDEADBEEF);
        chk("t1_fill_addr", fill_addr_seen, 32'h40);
        chk("t1_hits", hit_count, 1);
        chk("t1_misses", miss_count, 1);

        // Partial byte write on a hit, then read it back with no pmem traffic.
        w0 = wb_cnt;
        f0 = fill_cnt;
        cpu_access(0, 1, 32'h44, 4'b0011, 32'h11223344);
        cpu_access(1, 0, 32'h44, 4'h0, 32'h0);
        chk("t2_rdata", last_rdata, 32'hAABB3344);
        chk("t2_no_pmem", (wb_cnt - w0) + (fill_cnt - f0), 0);

        // Fill set 2, re-touch 0x040, then a fifth tag replaces the PLRU way.
        cpu_access(1, 0, 32'h140, 4'h0, 32'h0);
        cpu_access(1, 0, 32'h240, 4'h0, 32'h0);
        cpu_access(1, 0, 32'h340, 4'h0, 32'h0);
        cpu_access(1, 0, 32'h40, 4'h0, 32'h0);
        w0 = wb_cnt;
        cpu_access(1, 0, 32'h440, 4'h0, 32'h0);
        chk("t3_fill_addr", fill_addr_seen, 32'h440);
        chk("t3_no_wb", wb_cnt - w0, 0);

        // Dirty 0x140, steer the PLRU onto it, and evict it.
        cpu_access(0, 1, 32'h148, 4'hF, 32'hCAFEF00D);
        cpu_access(1, 0, 32'h40, 4'h0, 32'h0);
        cpu_access(1, 0, 32'h340, 4'h0, 32'h0);
        w0 = wb_cnt;
        cpu_access(1, 0, 32'h540, 4'h0, 32'h0);
        chk("t4_wb_count", wb_cnt - w0, 1);
        chk("t4_wb_addr", wb_addr_seen, 32'h140);
        chk("t4_wb_word", wb_data_seen[95:64], 32'hCAFEF00D);
        chk("t4_fill_addr", fill_addr_seen, 32'h540);

        // Reset while a fill is outstanding.
        hold = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1;
        mem_address = 32'h1000;
        wait_c = 0;
        do begin
            @(negedge clk);
            wait_c++;
        end while (!pmem_read && wait_c < 50);
        chk("t5_fill_req", pmem_read, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_pmem_read_low", pmem_read, 0);
        chk("t5_hits", hit_count, 0);
        chk("t5_misses", miss_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_read = 0;
        hold = 1'b0;
        m_reset();
        stray_req++;
        repeat (3) @(negedge clk);
        chk("t5_stray_resp", {pmem_read, pmem_write, mem_resp}, 3'b000);
        cpu_access(1, 0, 32'h1000, 4'h0, 32'h0);
        chk("t5_remiss", miss_count, 1);

        // Read and write together on a hit acts as a write.
        cpu_access(1, 1, 32'h1004, 4'hF, 32'h600DF00D);
        cpu_access(1, 0, 32'h1100, 4'h0, 32'h0);
        cpu_access(1, 0, 32'h1200, 4'h0, 32'h0);
        cpu_access(1, 0, 32'h1300, 4'h0, 32'h0);
        w0 = wb_cnt;
        cpu_access(1, 0, 32'h1400, 4'h0, 32'h0);
        chk("t6_wb_count", wb_cnt - w0, 1);
        chk("t6_wb_addr", wb_addr_seen, 32'h1000);
        chk("t6_wb_word", wb_data_seen[63:32], 32'h600DF00D);

        // Random traffic over a few tags so hits, evictions and writebacks mix.
        for (int i = 0; i < 150; i++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 7)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            cpu_access(op != 2, op >= 2, a, 4'($urandom_range(0, 15)), $urandom);
        end

        chk("pmem_exclusive", both_hi, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
